// File: rtl/map_discrete_latch.sv
// Discrete-logic bank latch mapper: one CPU-writable register at $8000-$FFFF
// split into PRG/CHR bank fields (or PRG + mirroring), with save-state access.
module map_discrete_latch #(
  parameter int         MODE     = 0,
  parameter int         PRG_W    = 2,
  parameter int         CHR_W    = 4,
  parameter int         BUS_CF   = 0,
  parameter int         IGN_8000 = 0,
  parameter int         RMW_FILT = 1,
  parameter logic [7:0] MAP_IDX  = 8'd11
) (
  input  logic             m2,
  input  logic             map_rst_n,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data,
  input  logic             cpu_rw,
  input  logic [7:0]       prg_do,
  input  logic             sst_act,
  input  logic             sst_we_reg,
  input  logic [7:0]       sst_addr,
  input  logic [7:0]       sst_dato,
  output logic [7:0]       sst_di,
  output logic [PRG_W-1:0] prg_bank,
  output logic [CHR_W-1:0] chr_bank,
  output logic             mir_sel,
  output logic             wr_ack
);

  logic             prev_wr;
  logic             raw_wr;
  logic             ign_wr;
  logic             rmw_drop;
  logic             accept;
  logic [7:0]       eff_data;
  logic [PRG_W-1:0] prg_nxt;
  logic [CHR_W-1:0] chr_nxt;
  logic             mir_nxt;
  logic             unused_bits;

  assign raw_wr   = cpu_addr[15] & ~cpu_rw;
  assign ign_wr   = (IGN_8000 != 0) && (cpu_addr == 16'h8000);
  assign rmw_drop = (RMW_FILT != 0) && prev_wr;
  assign accept   = raw_wr & ~ign_wr & ~rmw_drop & ~sst_act;
  // A ROM driving the bus during the write wins any 0 bit (open-drain-like AND).
  assign eff_data = (BUS_CF != 0) ? (cpu_data & prg_do) : cpu_data;

  // Field bits not mapped for a given width/MODE are intentionally ignored.
  assign unused_bits = &{1'b0, eff_data, sst_dato};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    prg_nxt = prg_bank;
    chr_nxt = chr_bank;
    mir_nxt = mir_sel;
    if (sst_act) begin
      if (sst_we_reg && sst_addr == 8'd0) begin
        prg_nxt = sst_dato[PRG_W-1:0];
        chr_nxt = (MODE == 2) ? '0 : sst_dato[4 +: CHR_W];
      end else if (sst_we_reg && sst_addr == 8'd1) begin
        mir_nxt = (MODE == 2) ? sst_dato[0] : 1'b0;
      end
    end else if (accept) begin
      if (MODE == 1) begin
        prg_nxt = eff_data[4 +: PRG_W];
        chr_nxt = eff_data[0 +: CHR_W];
      end else if (MODE == 2) begin
        prg_nxt = eff_data[0 +: PRG_W];
        mir_nxt = eff_data[4];
      end else begin
        prg_nxt = eff_data[0 +: PRG_W];
        chr_nxt = eff_data[4 +: CHR_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      prg_bank <= '0;
      chr_bank <= '0;
      mir_sel  <= 1'b0;
      prev_wr  <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      prg_bank <= prg_nxt;
      chr_bank <= chr_nxt;
      mir_sel  <= mir_nxt;
      prev_wr  <= raw_wr & ~sst_act;
      wr_ack   <= accept;
    end
  end

  always_comb begin
    sst_di = 8'hFF;
    case (sst_addr)
      8'd0:    sst_di = {4'(chr_bank), 4'(prg_bank)};
      8'd1:    sst_di = {7'd0, mir_sel};
      8'd127:  sst_di = MAP_IDX;
      default: sst_di = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_map_discrete_latch.sv
// Scoreboard bench for map_discrete_latch: four parameter variants share one
// CPU/save-state bus and are compared against a behavioural register model.
`timescale 1ns/1ps
module tb_map_discrete_latch;

  localparam int         N_DUT = 4;
  localparam int         P_MODE [N_DUT] = '{0, 0, 1, 2};
  localparam int         P_PRGW [N_DUT] = '{2, 2, 3, 2};
  localparam int         P_CHRW [N_DUT] = '{4, 4, 3, 4};
  localparam int         P_BUS  [N_DUT] = '{0, 1, 0, 0};
  localparam int         P_IGN  [N_DUT] = '{0, 1, 0, 0};
  localparam int         P_RMW  [N_DUT] = '{1, 0, 1, 1};
  localparam int         P_IDX  [N_DUT] = '{11, 11, 8'h3C, 8'h77};

  logic        m2 = 1'b0;
  logic        map_rst_n;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  prg_do = 8'hFF;
  logic        sst_act = 1'b0;
  logic        sst_we_reg = 1'b0;
  logic [7:0]  sst_addr = 8'h02;
  logic [7:0]  sst_dato = 8'h00;

  logic [1:0] prg0, prg1, prg3;
  logic [2:0] prg2, chr2;
  logic [3:0] chr0, chr1, chr3;
  logic [7:0] sdi0, sdi1, sdi2, sdi3;
  logic       mir0, mir1, mir2, mir3, ack0, ack1, ack2, ack3;

  logic [7:0] o_prg [N_DUT];
  logic [7:0] o_chr [N_DUT];
  logic [7:0] o_sdi [N_DUT];
  logic       o_mir [N_DUT];
  logic       o_ack [N_DUT];

  always #10 m2 = ~m2;

  map_discrete_latch #(.MODE(0), .PRG_W(2), .CHR_W(4), .BUS_CF(0), .IGN_8000(0),
                       .RMW_FILT(1), .MAP_IDX(8'd11)) dut0 (
    .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sdi0), .prg_bank(prg0),
    .chr_bank(chr0), .mir_sel(mir0), .wr_ack(ack0));

  map_discrete_latch #(.MODE(0), .PRG_W(2), .CHR_W(4), .BUS_CF(1), .IGN_8000(1),
                       .RMW_FILT(0), .MAP_IDX(8'd11)) dut1 (
    .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sdi1), .prg_bank(prg1),
    .chr_bank(chr1), .mir_sel(mir1), .wr_ack(ack1));

  map_discrete_latch #(.MODE(1), .PRG_W(3), .CHR_W(3), .BUS_CF(0), .IGN_8000(0),
                       .RMW_FILT(1), .MAP_IDX(8'h3C)) dut2 (
    .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sdi2), .prg_bank(prg2),
    .chr_bank(chr2), .mir_sel(mir2), .wr_ack(ack2));

  map_discrete_latch #(.MODE(2), .PRG_W(2), .CHR_W(4), .BUS_CF(0), .IGN_8000(0),
                       .RMW_FILT(1), .MAP_IDX(8'h77)) dut3 (
    .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sdi3), .prg_bank(prg3),
    .chr_bank(chr3), .mir_sel(mir3), .wr_ack(ack3));

  assign o_prg[0] = 8'(prg0);  assign o_chr[0] = 8'(chr0);
  assign o_prg[1] = 8'(prg1);  assign o_chr[1] = 8'(chr1);
  assign o_prg[2] = 8'(prg2);  assign o_chr[2] = 8'(chr2);
  assign o_prg[3] = 8'(prg3);  assign o_chr[3] = 8'(chr3);
  assign o_sdi[0] = sdi0;  assign o_sdi[1] = sdi1;
  assign o_sdi[2] = sdi2;  assign o_sdi[3] = sdi3;
  assign o_mir[0] = mir0;  assign o_mir[1] = mir1;
  assign o_mir[2] = mir2;  assign o_mir[3] = mir3;
  assign o_ack[0] = ack0;  assign o_ack[1] = ack1;
  assign o_ack[2] = ack2;  assign o_ack[3] = ack3;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] prg;
    logic [7:0] chr;
    logic [7:0] sdi;
    logic       mir;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Architectural model state, one entry per DUT variant.
  int m_prg [N_DUT];
  int m_chr [N_DUT];
  int m_mir [N_DUT];
  int m_prev[N_DUT];
  int m_ack [N_DUT];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int mask(input int w);
    return (1 << w) - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_DUT; i++) begin
      m_prg[i] = 0; m_chr[i] = 0; m_mir[i] = 0; m_prev[i] = 0; m_ack[i] = 0;
    end
  endtask

  // Applies one falling edge worth of bus activity to the model and queues
  // the outputs every variant must show after that edge.
  task automatic model_step();
    int   d, lo, hi;
    bit   raw, acc;
    exp_t e;
    raw = cpu_addr[15] && !cpu_rw;
    for (int i = 0; i < N_DUT; i++) begin
      if (sst_act) begin
        m_prev[i] = 0;
        m_ack[i]  = 0;
        if (sst_we_reg && sst_addr == 8'd0) begin
          m_prg[i] = sst_dato & mask(P_PRGW[i]);
          m_chr[i] = (P_MODE[i] == 2) ? 0 : (sst_dato >> 4) & mask(P_CHRW[i]);
        end else if (sst_we_reg && sst_addr == 8'd1) begin
          m_mir[i] = (P_MODE[i] == 2) ? sst_dato & 1 : 0;
        end
      end else begin
        acc = raw && !(P_IGN[i] != 0 && cpu_addr == 16'h8000)
                  && !(P_RMW[i] != 0 && m_prev[i] != 0);
        d  = (P_BUS[i] != 0) ? (cpu_data & prg_do) : cpu_data;
        lo = d % 16;
        hi = d / 16;
        if (acc) begin
          case (P_MODE[i])
            1:       begin m_prg[i] = hi & mask(P_PRGW[i]); m_chr[i] = lo & mask(P_CHRW[i]); end
            2:       begin m_prg[i] = lo & mask(P_PRGW[i]); m_mir[i] = hi & 1; end
            default: begin m_prg[i] = lo & mask(P_PRGW[i]); m_chr[i] = hi & mask(P_CHRW[i]); end
          endcase
        end
        m_ack[i]  = acc;
        m_prev[i] = raw;
      end
      e.idx = 2'(i);
      e.prg = 8'(m_prg[i]);
      e.chr = 8'(m_chr[i]);
      e.mir = m_mir[i][0];
      e.ack = m_ack[i][0];
      case (sst_addr)
        8'd0:    e.sdi = 8'(m_chr[i] * 16 + m_prg[i]);
        8'd1:    e.sdi = 8'(m_mir[i]);
        8'd127:  e.sdi = 8'(P_IDX[i]);
        default: e.sdi = 8'hFF;
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw,
                       input logic [7:0] pd, input logic sa, input logic swe,
                       input logic [7:0] sad, input logic [7:0] sdo);
    @(posedge m2);
    map_rst_n  = 1'b1;
    cpu_addr   = a;
    cpu_data   = d;
    cpu_rw     = rw;
    prg_do     = pd;
    sst_act    = sa;
    sst_we_reg = swe;
    sst_addr   = sad;
    sst_dato   = sdo;
    model_step();
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic [7:0] pd);
    drive(a, d, 1'b0, pd, 1'b0, 1'b0, 8'd2, 8'h00);
  endtask

  task automatic cpu_rd();
    drive(16'h8123, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd2, 8'h00);
  endtask

  task automatic settle();
    @(negedge m2);
    #3;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s_prg%0d", tag, i), o_prg[i], 0);
      check($sformatf("%s_chr%0d", tag, i), o_chr[i], 0);
      check($sformatf("%s_mir%0d", tag, i), o_mir[i], 0);
      check($sformatf("%s_ack%0d", tag, i), o_ack[i], 0);
    end
  endtask

  // Monitor: after each falling edge, compare every variant with its queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge m2);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("prg[%0d]", e.idx), o_prg[e.idx], e.prg);
        check($sformatf("chr[%0d]", e.idx), o_chr[e.idx], e.chr);
        check($sformatf("mir[%0d]", e.idx), o_mir[e.idx], e.mir);
        check($sformatf("ack[%0d]", e.idx), o_ack[e.idx], e.ack);
        check($sformatf("sst_di[%0d]", e.idx), o_sdi[e.idx], e.sdi);
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  sad;
    int          wait_cnt;
    model_reset();
    map_rst_n = 1'b1;
    #1 map_rst_n = 1'b0;
    #2 check_all_zero("por");

    // Single write with MODE0 layout; reset released on the preceding rise.
    cpu_wr(16'h8123, 8'hA7, 8'hFF);
    settle();
    check("w29_prg", o_prg[0], 2'b11);
    check("w29_chr", o_chr[0], 4'hA);
    check("w29_ack", o_ack[0], 1);
    cpu_rd();
    settle();
    check("w29_ack_end", o_ack[0], 0);

    // Bus conflict: ROM byte masks the CPU byte.
    cpu_wr(16'h8123, 8'hFF, 8'h52);
    settle();
    check("bc_prg", o_prg[1], 2'b10);
    check("bc_chr", o_chr[1], 4'h5);

    // Back-to-back writes: only the first is taken where filtering is on.
    cpu_rd();
    cpu_wr(16'h8123, 8'h11, 8'hFF);
    cpu_wr(16'h8123, 8'h22, 8'hFF);
    settle();
    check("rmw_prg", o_prg[0], 1);
    check("rmw_chr", o_chr[0], 1);
    check("rmw_ack", o_ack[0], 0);
    cpu_rd();
    cpu_wr(16'h8123, 8'h22, 8'hFF);
    settle();
    check("rmw_after_rd_chr", o_chr[0], 2);

    // Exact $8000 ignored on the IGN_8000 variant.
    cpu_wr(16'h8123, 8'h00, 8'hFF);
    cpu_wr(16'h8000, 8'hFF, 8'hFF);
    settle();
    check("ign_prg", o_prg[1], 0);
    check("ign_chr", o_chr[1], 0);
    cpu_wr(16'h8001, 8'hFF, 8'hFF);
    settle();
    check("ign_8001_prg", o_prg[1], 2'b11);
    check("ign_8001_chr", o_chr[1], 4'hF);

    // Save-state load with a concurrent CPU write, then read back.
    cpu_rd();
    drive(16'h8123, 8'h45, 1'b0, 8'hFF, 1'b1, 1'b1, 8'd0, 8'h93);
    settle();
    check("sst_prg", o_prg[0], 2'b11);
    check("sst_chr", o_chr[0], 4'h9);
    check("sst_di0", o_sdi[0], 8'h93);
    check("sst_ack", o_ack[0], 0);
    drive(16'h8123, 8'h45, 1'b0, 8'hFF, 1'b1, 1'b0, 8'd127, 8'h00);
    settle();
    check("sst_di127", o_sdi[0], 8'h0B);
    drive(16'h0000, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 8'd1, 8'h01);

    // Asynchronous reset while m2 is low, then a MODE2 write on the first edge.
    cpu_wr(16'h8123, 8'hFF, 8'hFF);
    settle();
    #2 map_rst_n = 1'b0;
    #2 check_all_zero("mid_rst");
    model_reset();
    cpu_wr(16'h9000, 8'h15, 8'hFF);
    settle();
    check("m2_prg", o_prg[3], 2'b01);
    check("m2_mir", o_mir[3], 1);
    check("m2_chr", o_chr[3], 0);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 16'h8000;
        1, 2, 3, 4, 5: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        default: a = 16'($urandom_range(0, 16'h7FFF));
      endcase
      case ($urandom_range(0, 3))
        0:       sad = 8'd0;
        1:       sad = 8'd1;
        2:       sad = 8'd127;
        default: sad = 8'($urandom_range(0, 255));
      endcase
      drive(a, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0,
            8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
            1'($urandom_range(0, 1)), sad, 8'($urandom_range(0, 255)));
    end
    cpu_rd();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 5) begin
      @(negedge m2);
      #5;
      wait_cnt++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_discrete_latch.md
MAP_DISCRETE_LATCH -- requirements
Module: map_discrete_latch

Interface
REQ-001 SHALL take parameter MODE, default 0: field layout (0 = prg d[3:0]/chr d[7:4]; 1 = prg d[7:4]/chr d[3:0]; 2 = prg d[3:0]/mirror d[4], no chr).
REQ-002 SHALL take parameter PRG_W, default 2: prg_bank width, legal 1..4.
REQ-003 SHALL take parameter CHR_W, default 4: chr_bank width, legal 1..4.
REQ-004 SHALL take parameter BUS_CF, default 0: 1 enables bus-conflict emulation.
REQ-005 SHALL take parameter IGN_8000, default 0: 1 ignores writes to exactly $8000.
REQ-006 SHALL take parameter RMW_FILT, default 1: 1 drops back-to-back writes.
REQ-007 SHALL take parameter MAP_IDX, default 8'd11: value returned at save-state address 127.
REQ-008 SHALL have port m2  in  1: CPU M2; the only clock; all state updates on its falling edge.
REQ-009 SHALL have port map_rst_n  in  1: reset, asynchronous, active-low.
REQ-010 SHALL have ports cpu_addr  in  16, cpu_data  in  8, cpu_rw  in  1 (1 = read): CPU bus.
REQ-011 SHALL have port prg_do  in  8: PRG ROM data at cpu_addr, used for bus conflicts.
REQ-012 SHALL have ports sst_act  in  1, sst_we_reg  in  1, sst_addr  in  8, sst_dato  in  8: save-state control and write data.
REQ-013 SHALL have port sst_di  out  8: save-state read data, combinational.
REQ-014 SHALL have ports prg_bank  out  PRG_W, chr_bank  out  CHR_W, mir_sel  out  1: registered bank state.
REQ-015 SHALL have port wr_ack  out  1: one-cycle pulse after an accepted register write.

Function
REQ-016 Raw write SHALL be cpu_addr[15]=1 & cpu_rw=0 at an m2 falling edge.
REQ-017 Raw write SHALL be ignored when IGN_8000=1 & cpu_addr=16'h8000.
REQ-018 Effective data SHALL be cpu_data & prg_do when BUS_CF=1, else cpu_data.
REQ-019 Register prev_wr SHALL capture raw write (including ignored writes) every edge; with RMW_FILT=1, a raw write while prev_wr=1 SHALL be dropped, so a run of consecutive writes accepts only the first.
REQ-020 Accepted write SHALL load fields per MODE from effective data in the same edge; outputs valid after that edge (latency 1 edge).
REQ-021 MODE 0/1 SHALL hold mir_sel=0; MODE 2 SHALL hold chr_bank=0.
REQ-022 wr_ack SHALL be 1 for exactly the edge interval following an accepted write, else 0.
REQ-023 While sst_act=1, CPU writes SHALL be blocked, prev_wr cleared, wr_ack 0.
REQ-024 sst_we_reg & sst_addr=0 SHALL load prg_bank=dato[PRG_W-1:0], chr_bank=dato[4 +: CHR_W]; sst_addr=1 SHALL load mir_sel=dato[0].
REQ-025 sst_di SHALL be: addr 0 -> {zero-extended chr_bank, zero-extended prg_bank} in [7:4]/[3:0]; addr 1 -> {7'd0, mir_sel}; addr 127 -> MAP_IDX; else 8'hFF.
REQ-026 Reads (cpu_rw=1) and writes with cpu_addr[15]=0 SHALL not change bank state but SHALL clear prev_wr.

Reset
REQ-027 map_rst_n=0 SHALL immediately force prg_bank=0, chr_bank=0, mir_sel=0, prev_wr=0, wr_ack=0, regardless of m2.
REQ-028 Reset SHALL take priority over save-state and CPU writes; a write on the first edge after release SHALL be accepted.

Verification
REQ-029 MODE0, PRG_W=2, CHR_W=4: write $8123 data 8'hA7 -> prg_bank=2'b11, chr_bank=4'hA, wr_ack pulse 1 cycle.
REQ-030 BUS_CF=1: write data 8'hFF with prg_do=8'h52 -> prg_bank=2'b10, chr_bank=4'h5.
REQ-031 RMW_FILT=1: writes 8'h11 then 8'h22 on consecutive edges -> banks reflect 8'h11, one wr_ack; after one read edge, write 8'h22 accepted.
REQ-032 IGN_8000=1: write $8000 data 8'hFF -> no change; write $8001 data 8'hFF -> prg_bank=2'b11, chr_bank=4'hF.
REQ-033 sst_act=1, sst_we_reg, addr 0 dato 8'h93 -> prg_bank=2'b11, chr_bank=4'h9, sst_di@0=8'h93, sst_di@127=8'h0B; concurrent CPU write ignored.
REQ-034 Assert map_rst_n=0 mid-run between m2 edges -> all outputs 0 immediately; MODE2 write 8'h15 after release -> prg_bank=2'b01, mir_sel=1.
